// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares one single-port data memory between two requesters.
//   Port 0 (processor MEM stage) normally wins; port 1 (loader/debug master)
//   is forced a grant once it has been denied STARVE_LIMIT cycles in a row.
//   Read data comes back on the requesting port with a one-cycle rvalid
//   pulse, READ_LAT+1 clocks after the grant.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   p0_req/we/addr/wdata      port 0 request (held until p0_gnt)
//   p0_gnt                    port 0 granted this cycle (combinational)
//   p0_rvalid/p0_rdata        port 0 read return (registered)
//   p1_*                      same set for port 1
//   dm_clka/ena/wea/addra/dina  DM port A controls (zeros when idle)
//   dm_douta                  DM read data, valid READ_LAT clocks after ena
module dm_port_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 32,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              dm_clka,
    output logic              dm_ena,
    output logic              dm_wea,
    output logic [ADDR_W-1:0] dm_addra,
    output logic [DATA_W-1:0] dm_dina,
    input  logic [DATA_W-1:0] dm_douta
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]    starve_cnt_reg, starve_cnt_next;
    logic                force1;
    logic                gnt0, gnt1;

    // Read-tag pipeline: one entry per issued access, aligned with DM latency.
    logic [READ_LAT-1:0] pipe_valid_reg, pipe_valid_next;
    logic [READ_LAT-1:0] pipe_tag_reg, pipe_tag_next;
    logic                push_valid, push_tag;
    logic                out_valid, out_tag;

    logic                p0_rvalid_reg, p1_rvalid_reg;
    logic [DATA_W-1:0]   p0_rdata_reg, p1_rdata_reg;

    assign dm_clka = clk;

    // Arbitration: port 0 priority unless port 1 has hit its starvation limit.
    always_comb begin
        force1 = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
        gnt1   = p1_req & (~p0_req | force1);
        gnt0   = p0_req & ~gnt1;
    end

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    always_comb begin
        starve_cnt_next = '0;
        if (p1_req && !gnt1) begin
            starve_cnt_next = force1 ? starve_cnt_reg : starve_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // DM mux: granted port drives the memory, everything zero when idle.
    always_comb begin
        dm_ena   = gnt0 | gnt1;
        dm_wea   = 1'b0;
        dm_addra = '0;
        dm_dina  = '0;
        if (gnt1) begin
            dm_wea   = p1_we;
            dm_addra = p1_addr;
            dm_dina  = p1_wdata;
        end else if (gnt0) begin
            dm_wea   = p0_we;
            dm_addra = p0_addr;
            dm_dina  = p0_wdata;
        end
    end

    // Writes enter the pipeline as bubbles so returns stay in issue order.
    assign push_valid = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
    assign push_tag   = gnt1;

    genvar gi;
    generate
        for (gi = 0; gi < READ_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign pipe_valid_next[gi] = push_valid;
                assign pipe_tag_next[gi]   = push_tag;
            end else begin : g_body
                assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
                assign pipe_tag_next[gi]   = pipe_tag_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_reg <= '0;
            pipe_tag_reg   <= '0;
        end else begin
            pipe_valid_reg <= pipe_valid_next;
            pipe_tag_reg   <= pipe_tag_next;
        end
    end

    // The last stage lines up with the cycle in which dm_douta is valid.
    assign out_valid = pipe_valid_reg[READ_LAT-1];
    assign out_tag   = pipe_tag_reg[READ_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid_reg <= 1'b0;
            p1_rvalid_reg <= 1'b0;
            p0_rdata_reg  <= '0;
            p1_rdata_reg  <= '0;
        end else begin
            p0_rvalid_reg <= out_valid & ~out_tag;
            p1_rvalid_reg <= out_valid & out_tag;
            if (out_valid && !out_tag) begin
                p0_rdata_reg <= dm_douta;
            end
            if (out_valid && out_tag) begin
                p1_rdata_reg <= dm_douta;
            end
        end
    end

    assign p0_rvalid = p0_rvalid_reg;
    assign p1_rvalid = p1_rvalid_reg;
    assign p0_rdata  = p0_rdata_reg;
    assign p1_rdata  = p1_rdata_reg;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter. Two instances share the same request
// stimulus: dut (READ_LAT=1) and dut3 (READ_LAT=3), each with its own DM
// read-latency model over a common memory array.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [6:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;

    // READ_LAT=1 instance
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        dm_clka, dm_ena, dm_wea;
    logic [6:0]  dm_addra;
    logic [31:0] dm_dina, dm_douta;

    // READ_LAT=3 instance
    logic        p0_gnt_l3, p0_rvalid_l3, p1_gnt_l3, p1_rvalid_l3;
    logic [31:0] p0_rdata_l3, p1_rdata_l3;
    logic        dm_clka_l3, dm_ena_l3, dm_wea_l3;
    logic [6:0]  dm_addra_l3;
    logic [31:0] dm_dina_l3, dm_douta_l3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .dm_clka(dm_clka), .dm_ena(dm_ena), .dm_wea(dm_wea),
        .dm_addra(dm_addra), .dm_dina(dm_dina), .dm_douta(dm_douta)
    );

    dm_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt_l3), .p0_rvalid(p0_rvalid_l3), .p0_rdata(p0_rdata_l3),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt_l3), .p1_rvalid(p1_rvalid_l3), .p1_rdata(p1_rdata_l3),
        .dm_clka(dm_clka_l3), .dm_ena(dm_ena_l3), .dm_wea(dm_wea_l3),
        .dm_addra(dm_addra_l3), .dm_dina(dm_dina_l3), .dm_douta(dm_douta_l3)
    );

    // DM model: preloaded while reset is high, write-first on a write.
    logic [31:0] mem [128];
    logic [31:0] rd1;
    logic [31:0] rd3 [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hA5A5_0000 | i;
            mem[5] <= 32'hDEAD_BEEF;
        end else if (dm_ena && dm_wea) begin
            mem[dm_addra] <= dm_dina;
        end
        if (dm_ena) rd1 <= dm_wea ? dm_dina : mem[dm_addra];
        if (dm_ena_l3) rd3[0] <= dm_wea_l3 ? dm_dina_l3 : mem[dm_addra_l3];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    assign dm_douta    = rd1;
    assign dm_douta_l3 = rd3[2];

    function automatic logic [31:0] memval(input int a);
        return (a == 5) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input int a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input int a1, input logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = 7'(a0); p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = 7'(a1); p1_wdata = d1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_p0_rvalid"}, {31'h0, p0_rvalid}, 32'h0);
        check({tag, "_p1_rvalid"}, {31'h0, p1_rvalid}, 32'h0);
        check({tag, "_p0_rdata"}, p0_rdata, 32'h0);
        check({tag, "_p1_rdata"}, p1_rdata, 32'h0);
        check({tag, "_gnt"}, {30'h0, p1_gnt, p0_gnt}, 32'h0);
        check({tag, "_dm_ena"}, {31'h0, dm_ena}, 32'h0);
        check({tag, "_dm_wea"}, {31'h0, dm_wea}, 32'h0);
        check({tag, "_dm_addra"}, {25'h0, dm_addra}, 32'h0);
        check({tag, "_dm_dina"}, dm_dina, 32'h0);
        check({tag, "_l3_rvalid"}, {30'h0, p1_rvalid_l3, p0_rvalid_l3}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Reset state
        @(negedge clk);
        check_quiet("reset");
        $display("reset: outputs checked while rst high");
        @(negedge clk);
        rst = 1'b0;

        // Test 1: reset with two reads in flight
        next_cycle();
        drive(1'b1, 1'b0, 5, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 6, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1;
        check_quiet("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t1_p0_rvalid", {31'h0, p0_rvalid}, 32'h0);
            check("t1_l3_p0_rvalid", {31'h0, p0_rvalid_l3}, 32'h0);
        end
        $display("t1: reset mid-run, two reads discarded");

        // Test 2 / 6: p0 read addr 5, returns at +2 (lat 1) and +4 (lat 3)
        next_cycle();
        drive(1'b1, 1'b0, 5, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        @(negedge clk);
        check("t2_p0_gnt", {31'h0, p0_gnt}, 32'h1);
        check("t2_p1_gnt", {31'h0, p1_gnt}, 32'h0);
        check("t2_dm_ena", {31'h0, dm_ena}, 32'h1);
        check("t2_dm_wea", {31'h0, dm_wea}, 32'h0);
        check("t2_dm_addra", {25'h0, dm_addra}, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 1) idle();
            @(negedge clk);
            check("t2_p0_rvalid", {31'h0, p0_rvalid}, (k == 2) ? 32'h1 : 32'h0);
            if (k == 2) check("t2_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
            check("t6_p0_rvalid", {31'h0, p0_rvalid_l3}, (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) check("t6_p0_rdata", p0_rdata_l3, 32'hDEAD_BEEF);
        end
        $display("t2/t6: p0 read addr 5 rdata=%h rdata_l3=%h", p0_rdata, p0_rdata_l3);

        // Test 3: both request every cycle -> 0,0,0,0,1,0,0,0,0,1
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive(1'b1, 1'b0, c, 32'h0, 1'b1, 1'b0, 20 + c, 32'h0);
            @(negedge clk);
            check("t3_p1_gnt", {31'h0, p1_gnt}, (c == 4 || c == 9) ? 32'h1 : 32'h0);
            check("t3_p0_gnt", {31'h0, p0_gnt}, (c == 4 || c == 9) ? 32'h0 : 32'h1);
            $display("t3: cycle %0d gnt0=%b gnt1=%b", c, p0_gnt, p1_gnt);
        end
        next_cycle();
        idle();
        repeat (6) next_cycle();

        // Test 4: p1 write addr 10, p0 read addr 10 next cycle
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b1, 10, 32'h1234_5678);
        @(negedge clk);
        check("t4_p1_gnt", {31'h0, p1_gnt}, 32'h1);
        check("t4_p0_gnt", {31'h0, p0_gnt}, 32'h0);
        check("t4_dm_wea", {31'h0, dm_wea}, 32'h1);
        check("t4_dm_addra", {25'h0, dm_addra}, 32'd10);
        check("t4_dm_dina", dm_dina, 32'h1234_5678);
        next_cycle();
        drive(1'b1, 1'b0, 10, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        @(negedge clk);
        check("t4_p0_gnt_rd", {31'h0, p0_gnt}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 1) idle();
            @(negedge clk);
            check("t4_p1_rvalid", {31'h0, p1_rvalid}, 32'h0);
            check("t4_p0_rvalid", {31'h0, p0_rvalid}, (k == 2) ? 32'h1 : 32'h0);
            if (k == 2) check("t4_p0_rdata", p0_rdata, 32'h1234_5678);
        end
        $display("t4: write 10 then read 10 rdata=%h", p0_rdata);
        repeat (4) next_cycle();

        // Test 5: alternating p0/p1 reads of addr 1..6 back-to-back
        for (int k = 0; k < 10; k++) begin
            int idx;
            logic in_rng;
            next_cycle();
            if (k < 6) begin
                if (k % 2 == 0) drive(1'b1, 1'b0, k + 1, 32'h0, 1'b0, 1'b0, 0, 32'h0);
                else            drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, k + 1, 32'h0);
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 6) begin
                check("t5_dm_ena", {31'h0, dm_ena}, 32'h1);
                check("t5_dm_addra", {25'h0, dm_addra}, 32'(k + 1));
            end
            idx    = k - 2;
            in_rng = (idx >= 0) && (idx < 6);
            check("t5_p0_rvalid", {31'h0, p0_rvalid}, (in_rng && idx % 2 == 0) ? 32'h1 : 32'h0);
            check("t5_p1_rvalid", {31'h0, p1_rvalid}, (in_rng && idx % 2 == 1) ? 32'h1 : 32'h0);
            if (in_rng) begin
                if (idx % 2 == 0) check("t5_p0_rdata", p0_rdata, memval(idx + 1));
                else              check("t5_p1_rdata", p1_rdata, memval(idx + 1));
                $display("t5: return %0d port=%0d data=%h", idx, idx % 2,
                         (idx % 2 == 0) ? p0_rdata : p1_rdata);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
